p_int_mac_acc: RTL

Sequential multiply-accumulate stage of the perceptron datapath. Accepts a stream of (input, weight) pairs over a valid/ready handshake, forms their products and sums each group of NUM consecutive products into one dot-product result. It feeds the power-of-two scaling stage (p_int_div_pow2), whose `in` is driven from `out_sum`. A 2-stage pipeline (product register, then accumulator) sits behind a one-entry output register with valid/ready backpressure.

---
 rtl/p_int_mac_acc.sv | 90 +++++++++
 1 files changed

// File: rtl/p_int_mac_acc.sv
// Multiply-accumulate stage: sums each group of NUM input*weight products into one
// dot product, through a product register, an accumulator and a one-entry output register.
module p_int_mac_acc #(
   parameter int SIGN     = 1,
   parameter int I_PREC   = 16,
   parameter int W_PREC   = 16,
   parameter int NUM      = 8,
   parameter int ACC_PREC = 40
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [I_PREC-1:0]   in_data,
   input  logic [W_PREC-1:0]   in_weight,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_PREC-1:0] out_sum
);

   localparam int P_W   = I_PREC + W_PREC;
   localparam int CNT_W = $clog2(NUM);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);

   logic [CNT_W-1:0]    cnt;
   logic [P_W-1:0]      data_ext;
   logic [P_W-1:0]      weight_ext;
   logic [P_W-1:0]      prod;
   logic [P_W-1:0]      p;
   logic                p_valid;
   logic                p_first;
   logic                p_last;
   logic [ACC_PREC-1:0] acc;
   logic [ACC_PREC-1:0] p_ext;
   logic [ACC_PREC-1:0] sum;
   logic                sign_d;
   logic                sign_w;
   logic                sign_p;
   logic                accept;
   logic                complete;

   assign sign_d = (SIGN != 0) && in_data[I_PREC-1];
   assign sign_w = (SIGN != 0) && in_weight[W_PREC-1];
   assign sign_p = (SIGN != 0) && p[P_W-1];

   // Low P_W bits of the product of the extended operands are exact in both modes.
   assign data_ext   = {{W_PREC{sign_d}}, in_data};
   assign weight_ext = {{I_PREC{sign_w}}, in_weight};
   assign prod       = data_ext * weight_ext;

   assign p_ext    = {{(ACC_PREC-P_W){sign_p}}, p};
   assign sum      = p_first ? p_ext : acc + p_ext;
   assign in_ready = !reset && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign complete = p_valid && p_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         p         <= '0;
         p_valid   <= 1'b0;
         p_first   <= 1'b0;
         p_last    <= 1'b0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
      end else begin
         p_valid <= accept;
         if (accept) begin
            p       <= prod;
            p_first <= (cnt == '0);
            p_last  <= (cnt == CNT_LAST);
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         end
         if (p_valid)
            acc <= sum;
         // A completion always wins over a consume on the same edge.
         if (complete) begin
            out_sum   <= sum;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   no_overwrite: assert property (@(posedge clk) disable iff (reset)
      !(complete && out_valid && !out_ready));

endmodule
